lsc_core_arbiter: RTL and testbench
===================================

Name: lsc_core_arbiter

Overview:
- Shares one loadStoreController core port among NUM_CORES FPU cores.
- Performs round-robin arbitration and latches the winning core's command fields (host addr, local addr, length, direction).
- Holds the grant for the whole transaction. Steers write data to the controller and routes ready, ack and read data back to the granted core only.
- Adds a watchdog so a stalled DMA cannot lock out the other cores.

Parameters:
- NUM_CORES, 4, number of requesting cores (2..8)
- IDX_W, 2, width of the grant index; equals clog2(NUM_CORES)
- GAP_CYCLES, 2, idle cycles inserted after each transaction before the next grant
- TIMEOUT_CYCLES, 4096, cycles without progress before the transaction is aborted; 0 disables the watchdog

Ports:
- clk  in  1  clock
- rst  in  1  reset
- core_req  in  NUM_CORES  per-core request; held high until that core's core_done
- core_rwn  in  NUM_CORES  per-core direction: 1 = read (DMA to local), 0 = write
- core_hostAddr  in  NUM_CORES*40  per-core host address, core i at bits [40i+39:40i]
- core_localAddr  in  NUM_CORES*14  per-core local address
- core_transferLength  in  NUM_CORES*16  per-core beat count
- core_writeData  in  NUM_CORES*128  per-core write beat
- core_ready  out  NUM_CORES  ready, forwarded to the granted core only
- core_ack  out  NUM_CORES  beat ack, forwarded to the granted core only
- core_readData  out  128  read beat, broadcast to all cores; qualify with core_ack
- core_done  out  NUM_CORES  1-cycle pulse at the end of a transaction
- core_err  out  NUM_CORES  1-cycle pulse when a transaction is aborted by the watchdog
- lsc_req  out  1  request to the controller
- lsc_ready  in  1  controller ready
- lsc_rwn  out  1  latched direction
- lsc_hostAddr  out  40  latched host address
- lsc_localAddr  out  14  latched local address
- lsc_transferLength  out  16  latched beat count
- lsc_ack  in  1  controller beat ack
- lsc_writeData  out  128  write beat from the granted core
- lsc_readData  in  128  controller read data
- grant_idx  out  IDX_W  current or last grant, for debug

Behaviour:
- Reset: rst, asynchronous, active-high; clock clk. While rst is high:
  - all outputs are 0
  - rr_ptr = 0, state = IDLE, all counters = 0
- Reset mid-transaction aborts silently: no done or err pulse.
- States are IDLE, LATCH, REQ, XFER, GAP.
- IDLE:
  - Round-robin search starts at rr_ptr. The first core with core_req=1 wins.
  - The winner index is registered and the state moves to LATCH.
  - If no request is pending, the state stays IDLE.
- LATCH, 1 cycle:
  - Register the winner's rwn, hostAddr, localAddr and transferLength onto the lsc_* command outputs.
  - Set rr_ptr = winner+1 modulo NUM_CORES, then go to REQ.
  - Result: IDLE to lsc_req=1 takes 2 cycles.
- REQ:
  - lsc_req = 1.
  - On the first cycle with lsc_ready=1, go to XFER.
- XFER:
  - lsc_req = core_req[g], where g is the granted core, so the controller sees the core's own hold and release.
  - core_ready[g] = lsc_ready and core_ack[g] = lsc_ack, both combinational.
  - Every other core's ready and ack is 0.
  - beat_cnt counts lsc_ack pulses, saturating at 16'hFFFF; this count is debug only.
  - On the first cycle with lsc_ready=0: pulse core_done[g], then go to GAP.
- lsc_writeData = core_writeData slice g, combinational, driven in all states; its value outside XFER is don't-care.
- core_readData = lsc_readData at all times.
- GAP:
  - Lasts GAP_CYCLES cycles with lsc_req=0, then go to IDLE.
  - This lets the controller return to its idle state.
  - With GAP_CYCLES=0, GAP lasts 1 cycle.
- Watchdog, active in REQ and XFER:
  - wd_cnt resets to 0 on entry and on any lsc_ack or lsc_ready edge.
  - When wd_cnt reaches TIMEOUT_CYCLES: pulse core_err[g] and force lsc_req=0.
  - After a timeout, no core_done is issued and the state goes to GAP.
- A transfer length of 0 is legal: completion is still detected on lsc_ready falling.
- A core that drops core_req during REQ before ready: the transaction continues. lsc_req stays high until lsc_ready is seen.
- Simultaneous requests: strict round-robin. No core waits more than NUM_CORES-1 transactions.
- A new request arriving during GAP is considered in the next IDLE cycle.

Decomposition:
- Shared package npu_lsc_pkg holds:
  - field widths: HOST_AW=40, LOCAL_AW=14, LEN_W=16, DATA_W=128
  - the state encoding, 3 bits
- One sub-module, rr_arbiter: request vector plus pointer in, one-hot and index out. It is purely combinational and is reused by later DMA-path arbiters.

Test Plan:
- Single core: core_req[1]=1, rwn=0, len=4, lsc_ready high for 6 cycles with 4 acks.
  - Required: lsc_req rises 2 cycles after core_req.
  - Required: lsc_hostAddr equals core 1's address.
  - Required: core_ack[1] pulses 4 times and all other acks stay 0.
  - Required: core_done[1] pulses once, followed by a 2-cycle gap.
- Contention: cores 0, 2 and 3 request simultaneously with rr_ptr=0.
  - Required: grants come in order 0, 2, 3.
  - Required: after core 3 re-requests together with core 0, the next grant is 0.
- Read: core 2 with rwn=1, len=2, lsc_readData=A then B.
  - Required: core_readData shows A and B while core_ack[2] is high.
  - Required: core_ack[0,1,3] stay 0.
- Timeout: TIMEOUT_CYCLES=16, lsc_ready held at 0 after grant.
  - Required: core_err pulses on cycle 16 of REQ and lsc_req drops.
  - Required: core_done does not pulse and the next requester is granted.
- Reset mid-XFER: assert rst during the beat-2 ack.
  - Required: all outputs 0 immediately, rr_ptr=0, no done or err pulse.
  - Required: after reset is released, a request is served normally.

Source files
------------

// File: rtl/npu_lsc_pkg.sv
// Shared definitions for the loadStoreController core-port arbiter.
// Field widths and the arbiter state encoding.
package npu_lsc_pkg;

   localparam int HOST_AW  = 40;
   localparam int LOCAL_AW = 14;
   localparam int LEN_W    = 16;
   localparam int DATA_W   = 128;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LATCH = 3'd1,
      ST_REQ   = 3'd2,
      ST_XFER  = 3'd3,
      ST_GAP   = 3'd4
   } lsc_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr wins.
// Returns the winner both one-hot and as an index.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt_oh,
   output logic [IW-1:0] gnt_idx,
   output logic          gnt_vld
);

   localparam logic [IW:0] NL = (IW+1)'(N);

   logic [IW:0]   sum;
   logic [IW-1:0] idx;

   // Walk the requests starting at ptr, wrapping at N.
   always_comb begin
      gnt_oh  = '0;
      gnt_idx = '0;
      gnt_vld = 1'b0;
      sum     = '0;
      idx     = '0;
      for (int k = 0; k < N; k++) begin
         sum = {1'b0, ptr} + (IW+1)'(k);
         if (sum >= NL) begin
            sum = sum - NL;
         end
         idx = sum[IW-1:0];
         if (!gnt_vld && req[idx]) begin
            gnt_vld     = 1'b1;
            gnt_idx     = idx;
            gnt_oh[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/lsc_core_arbiter.sv
// Shares one loadStoreController port among several FPU cores.
// Round-robin grant held per transaction, with a progress watchdog.
module lsc_core_arbiter
   import npu_lsc_pkg::*;
#(
   parameter int NUM_CORES      = 4,
   parameter int IDX_W          = 2,
   parameter int GAP_CYCLES     = 2,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_CORES-1:0]          core_req,
   input  logic [NUM_CORES-1:0]          core_rwn,
   input  logic [NUM_CORES*HOST_AW-1:0]  core_hostAddr,
   input  logic [NUM_CORES*LOCAL_AW-1:0] core_localAddr,
   input  logic [NUM_CORES*LEN_W-1:0]    core_transferLength,
   input  logic [NUM_CORES*DATA_W-1:0]   core_writeData,
   output logic [NUM_CORES-1:0]          core_ready,
   output logic [NUM_CORES-1:0]          core_ack,
   output logic [DATA_W-1:0]             core_readData,
   output logic [NUM_CORES-1:0]          core_done,
   output logic [NUM_CORES-1:0]          core_err,
   output logic                          lsc_req,
   input  logic                          lsc_ready,
   output logic                          lsc_rwn,
   output logic [HOST_AW-1:0]            lsc_hostAddr,
   output logic [LOCAL_AW-1:0]           lsc_localAddr,
   output logic [LEN_W-1:0]              lsc_transferLength,
   input  logic                          lsc_ack,
   output logic [DATA_W-1:0]             lsc_writeData,
   input  logic [DATA_W-1:0]             lsc_readData,
   output logic [IDX_W-1:0]              grant_idx
);

   lsc_state_e state_q, state_d;

   logic [IDX_W-1:0]     grant_q, grant_d;
   logic [NUM_CORES-1:0] gnt_oh_q, gnt_oh_d;
   logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic                 rwn_q, rwn_d;
   logic [HOST_AW-1:0]   host_q, host_d;
   logic [LOCAL_AW-1:0]  loc_q, loc_d;
   logic [LEN_W-1:0]     len_q, len_d;
   logic [LEN_W-1:0]     beat_cnt_q, beat_cnt_d;
   logic [31:0]          wd_cnt_q, wd_cnt_d;
   logic [31:0]          gap_cnt_q, gap_cnt_d;
   logic                 rdy_prev_q, rdy_prev_d;

   logic [NUM_CORES-1:0] arb_oh;
   logic [IDX_W-1:0]     arb_idx;
   logic                 arb_vld;

   logic                 sel_rwn;
   logic [HOST_AW-1:0]   sel_host;
   logic [LOCAL_AW-1:0]  sel_loc;
   logic [LEN_W-1:0]     sel_len;
   logic [DATA_W-1:0]    sel_wdata;

   logic req_o, done_o, err_o, fwd_o;
   logic req_g, progress, tmo;

   rr_arbiter #(
      .N  (NUM_CORES),
      .IW (IDX_W)
   ) u_rr (
      .req     (core_req),
      .ptr     (rr_ptr_q),
      .gnt_oh  (arb_oh),
      .gnt_idx (arb_idx),
      .gnt_vld (arb_vld)
   );

   // Pick the granted core's command and write-data slices.
   always_comb begin
      sel_rwn   = 1'b0;
      sel_host  = '0;
      sel_loc   = '0;
      sel_len   = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (grant_q == IDX_W'(i)) begin
            sel_rwn   = core_rwn[i];
            sel_host  = core_hostAddr[i*HOST_AW +: HOST_AW];
            sel_loc   = core_localAddr[i*LOCAL_AW +: LOCAL_AW];
            sel_len   = core_transferLength[i*LEN_W +: LEN_W];
            sel_wdata = core_writeData[i*DATA_W +: DATA_W];
         end
      end
   end

   assign req_g    = |(core_req & gnt_oh_q);
   assign progress = lsc_ack | (lsc_ready ^ rdy_prev_q);
   assign tmo      = (TIMEOUT_CYCLES != 0) && !progress &&
                     (wd_cnt_q == 32'(TIMEOUT_CYCLES - 1));

   // Transaction sequencing, watchdog and per-state outputs.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      gnt_oh_d   = gnt_oh_q;
      rr_ptr_d   = rr_ptr_q;
      rwn_d      = rwn_q;
      host_d     = host_q;
      loc_d      = loc_q;
      len_d      = len_q;
      beat_cnt_d = beat_cnt_q;
      wd_cnt_d   = wd_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      rdy_prev_d = lsc_ready;
      req_o      = 1'b0;
      done_o     = 1'b0;
      err_o      = 1'b0;
      fwd_o      = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (arb_vld) begin
               grant_d  = arb_idx;
               gnt_oh_d = arb_oh;
               state_d  = ST_LATCH;
            end
         end
         ST_LATCH: begin
            rwn_d      = sel_rwn;
            host_d     = sel_host;
            loc_d      = sel_loc;
            len_d      = sel_len;
            beat_cnt_d = '0;
            wd_cnt_d   = '0;
            rr_ptr_d   = (grant_q == IDX_W'(NUM_CORES - 1)) ?
                         '0 : grant_q + IDX_W'(1);
            state_d    = ST_REQ;
         end
         ST_REQ: begin
            wd_cnt_d = progress ? '0 : wd_cnt_q + 32'd1;
            if (lsc_ready) begin
               req_o    = 1'b1;
               wd_cnt_d = '0;
               state_d  = ST_XFER;
            end else if (tmo) begin
               err_o     = 1'b1;
               gap_cnt_d = '0;
               state_d   = ST_GAP;
            end else begin
               req_o = 1'b1;
            end
         end
         ST_XFER: begin
            fwd_o    = 1'b1;
            wd_cnt_d = progress ? '0 : wd_cnt_q + 32'd1;
            if (lsc_ack && beat_cnt_q != '1) begin
               beat_cnt_d = beat_cnt_q + LEN_W'(1);
            end
            if (!lsc_ready) begin
               req_o     = req_g;
               done_o    = 1'b1;
               gap_cnt_d = '0;
               state_d   = ST_GAP;
            end else if (tmo) begin
               err_o     = 1'b1;
               gap_cnt_d = '0;
               state_d   = ST_GAP;
            end else begin
               req_o = req_g;
            end
         end
         ST_GAP: begin
            if (gap_cnt_q + 32'd1 >= 32'(GAP_CYCLES)) begin
               state_d = ST_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + 32'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and command registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         grant_q    <= '0;
         gnt_oh_q   <= '0;
         rr_ptr_q   <= '0;
         rwn_q      <= 1'b0;
         host_q     <= '0;
         loc_q      <= '0;
         len_q      <= '0;
         beat_cnt_q <= '0;
         wd_cnt_q   <= '0;
         gap_cnt_q  <= '0;
         rdy_prev_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         gnt_oh_q   <= gnt_oh_d;
         rr_ptr_q   <= rr_ptr_d;
         rwn_q      <= rwn_d;
         host_q     <= host_d;
         loc_q      <= loc_d;
         len_q      <= len_d;
         beat_cnt_q <= beat_cnt_d;
         wd_cnt_q   <= wd_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
         rdy_prev_q <= rdy_prev_d;
      end
   end

   assign lsc_req            = req_o;
   assign lsc_rwn            = rwn_q;
   assign lsc_hostAddr       = host_q;
   assign lsc_localAddr      = loc_q;
   assign lsc_transferLength = len_q;
   assign grant_idx          = grant_q;

   assign core_ready = fwd_o ? (gnt_oh_q & {NUM_CORES{lsc_ready}}) : '0;
   assign core_ack   = fwd_o ? (gnt_oh_q & {NUM_CORES{lsc_ack}})   : '0;
   assign core_done  = done_o ? gnt_oh_q : '0;
   assign core_err   = err_o  ? gnt_oh_q : '0;

   assign lsc_writeData = rst ? '0 : sel_wdata;
   assign core_readData = rst ? '0 : lsc_readData;

endmodule

// File: tb/tb_lsc_core_arbiter.sv
// Self-checking bench for lsc_core_arbiter.
// Directed scenarios followed by randomized round-robin traffic.
module tb_lsc_core_arbiter;

   localparam int N   = 4;
   localparam int TMO = 16;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   core_req;
   logic [N-1:0]   core_rwn;
   logic [N*40-1:0]  core_hostAddr;
   logic [N*14-1:0]  core_localAddr;
   logic [N*16-1:0]  core_transferLength;
   logic [N*128-1:0] core_writeData;
   logic [N-1:0]   core_ready;
   logic [N-1:0]   core_ack;
   logic [127:0]   core_readData;
   logic [N-1:0]   core_done;
   logic [N-1:0]   core_err;
   logic           lsc_req;
   logic           lsc_ready;
   logic           lsc_rwn;
   logic [39:0]    lsc_hostAddr;
   logic [13:0]    lsc_localAddr;
   logic [15:0]    lsc_transferLength;
   logic           lsc_ack;
   logic [127:0]   lsc_writeData;
   logic [127:0]   lsc_readData;
   logic [1:0]     grant_idx;

   int n_assert = 0;
   int n_fail   = 0;

   logic [39:0] m_host [N];
   logic [13:0] m_loc  [N];
   logic [15:0] m_len  [N];
   logic        m_rwn  [N];
   logic [N-1:0] m_req;
   int          m_ptr;

   lsc_core_arbiter #(
      .NUM_CORES      (N),
      .IDX_W          (2),
      .GAP_CYCLES     (2),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .core_req            (core_req),
      .core_rwn            (core_rwn),
      .core_hostAddr       (core_hostAddr),
      .core_localAddr      (core_localAddr),
      .core_transferLength (core_transferLength),
      .core_writeData      (core_writeData),
      .core_ready          (core_ready),
      .core_ack            (core_ack),
      .core_readData       (core_readData),
      .core_done           (core_done),
      .core_err            (core_err),
      .lsc_req             (lsc_req),
      .lsc_ready           (lsc_ready),
      .lsc_rwn             (lsc_rwn),
      .lsc_hostAddr        (lsc_hostAddr),
      .lsc_localAddr       (lsc_localAddr),
      .lsc_transferLength  (lsc_transferLength),
      .lsc_ack             (lsc_ack),
      .lsc_writeData       (lsc_writeData),
      .lsc_readData        (lsc_readData),
      .grant_idx           (grant_idx)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout obs=running exp=finished");
      $fatal(1, "bench timed out");
   end

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(negedge clk);
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   function automatic int pick(input logic [N-1:0] m);
      for (int k = 0; k < N; k++) begin
         if (m[(m_ptr + k) % N]) return (m_ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic set_core(input int i, input bit rw, input int len);
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      m_host[i] = r[39:0];
      m_loc[i]  = 14'($urandom());
      m_len[i]  = 16'(len);
      m_rwn[i]  = rw;
      core_rwn[i] = rw;
      core_hostAddr[i*40 +: 40]       = m_host[i];
      core_localAddr[i*14 +: 14]      = m_loc[i];
      core_transferLength[i*16 +: 16] = m_len[i];
      core_req[i] = 1'b1;
      m_req[i]    = 1'b1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_req"},  128'(lsc_req), 128'(0));
      chk({tag, "_rdy"},  128'(core_ready), 128'(0));
      chk({tag, "_ack"},  128'(core_ack), 128'(0));
      chk({tag, "_done"}, 128'({core_done, core_err}), 128'(0));
      chk({tag, "_cmd"},
          128'({lsc_rwn, lsc_hostAddr, lsc_localAddr, lsc_transferLength}),
          128'(0));
      chk({tag, "_wd"},   lsc_writeData, 128'(0));
      chk({tag, "_rd"},   core_readData, 128'(0));
      chk({tag, "_gidx"}, 128'(grant_idx), 128'(0));
   endtask

   task automatic wait_req(output int lat);
      lat = 0;
      do begin
         step;
         #1;
         lat++;
      end while (lsc_req !== 1'b1 && lat < 40);
      chk("req_seen", 128'(lsc_req), 128'(1));
   endtask

   task automatic chk_cmd(input int g);
      chk("grant", 128'(grant_idx), 128'(g));
      chk("host",  128'(lsc_hostAddr), 128'(m_host[g]));
      chk("local", 128'(lsc_localAddr), 128'(m_loc[g]));
      chk("len",   128'(lsc_transferLength), 128'(m_len[g]));
      chk("rwn",   128'(lsc_rwn), 128'(m_rwn[g]));
   endtask

   task automatic do_txn(input int g, input int nb, output int lat);
      logic [127:0] d, w;
      logic [N-1:0] oh;
      oh = '0;
      oh[g] = 1'b1;
      wait_req(lat);
      chk_cmd(g);
      chk("req_rdy", 128'(core_ready), 128'(0));
      lsc_ready = 1'b1;
      for (int b = 0; b < nb; b++) begin
         step;
         d = rnd128();
         w = rnd128();
         lsc_ack = 1'b1;
         lsc_readData = d;
         core_writeData[g*128 +: 128] = w;
         #1;
         chk("ack",   128'(core_ack), 128'(oh));
         chk("rdy",   128'(core_ready), 128'(oh));
         chk("wdata", lsc_writeData, w);
         chk("rdata", core_readData, d);
         chk("early_done", 128'(core_done), 128'(0));
      end
      step;
      lsc_ack = 1'b0;
      #1;
      chk("ack_idle", 128'(core_ack), 128'(0));
      chk("rdy_hold", 128'(core_ready), 128'(oh));
      step;
      lsc_ready = 1'b0;
      #1;
      chk("done", 128'(core_done), 128'(oh));
      chk("no_err", 128'(core_err), 128'(0));
      step;
      core_req[g] = 1'b0;
      m_req[g]    = 1'b0;
      #1;
      chk("gap1_req", 128'(lsc_req), 128'(0));
      chk("gap1_done", 128'(core_done), 128'(0));
      step;
      #1;
      chk("gap2_req", 128'(lsc_req), 128'(0));
      m_ptr = (g + 1) % N;
   endtask

   task automatic do_tmo(input int g);
      int lat;
      logic [N-1:0] oh;
      oh = '0;
      oh[g] = 1'b1;
      wait_req(lat);
      chk_cmd(g);
      for (int c = 1; c <= TMO; c++) begin
         if (c > 1) begin
            step;
            #1;
         end
         if (c < TMO) begin
            chk("tmo_req_hi", 128'(lsc_req), 128'(1));
            chk("tmo_err_lo", 128'(core_err), 128'(0));
         end else begin
            chk("tmo_err", 128'(core_err), 128'(oh));
            chk("tmo_req_drop", 128'(lsc_req), 128'(0));
         end
         chk("tmo_no_done", 128'(core_done), 128'(0));
      end
      step;
      core_req[g] = 1'b0;
      m_req[g]    = 1'b0;
      #1;
      chk("tmo_gap1", 128'({lsc_req, core_err, core_done}), 128'(0));
      step;
      #1;
      chk("tmo_gap2", 128'(lsc_req), 128'(0));
      m_ptr = (g + 1) % N;
   endtask

   task automatic do_reset;
      step;
      rst = 1'b1;
      step;
      step;
      rst = 1'b0;
      m_ptr = 0;
   endtask

   initial begin
      int lat;
      int g;
      logic [N-1:0] oh0;
      rst = 1'b1;
      core_req = '0;
      core_rwn = '0;
      core_hostAddr = '0;
      core_localAddr = '0;
      core_transferLength = '0;
      for (int i = 0; i < N; i++) core_writeData[i*128 +: 128] = rnd128();
      lsc_ready = 1'b0;
      lsc_ack = 1'b0;
      lsc_readData = rnd128();
      m_req = '0;
      m_ptr = 0;
      step;
      step;
      #1;
      chk_zero("reset");
      step;
      rst = 1'b0;

      // single core 1, write, 4 beats
      set_core(1, 1'b0, 4);
      do_txn(1, 4, lat);
      chk("single_lat", 128'(lat), 128'(2));

      // contention 0,2,3 from rr_ptr 0
      do_reset;
      set_core(0, 1'b0, 1);
      set_core(2, 1'b0, 2);
      set_core(3, 1'b0, 1);
      do_txn(0, 1, lat);
      chk("cont0_lat", 128'(lat), 128'(2));
      do_txn(2, 2, lat);
      chk("cont2_lat", 128'(lat), 128'(3));
      do_txn(3, 1, lat);
      chk("cont3_lat", 128'(lat), 128'(3));
      set_core(0, 1'b0, 1);
      set_core(3, 1'b0, 1);
      do_txn(0, 1, lat);
      do_txn(3, 1, lat);

      // read by core 2
      set_core(2, 1'b1, 2);
      do_txn(2, 2, lat);

      // watchdog abort of core 1, core 2 served next
      set_core(1, 1'b0, 3);
      set_core(2, 1'b0, 1);
      g = pick(m_req);
      chk("tmo_pick", 128'(g), 128'(1));
      do_tmo(1);
      do_txn(2, 1, lat);
      chk("after_tmo_lat", 128'(lat), 128'(3));

      // reset during the second beat of a core 0 transfer
      set_core(0, 1'b0, 4);
      oh0 = 4'b0001;
      wait_req(lat);
      chk_cmd(0);
      lsc_ready = 1'b1;
      step;
      lsc_ack = 1'b1;
      #1;
      chk("mid_ack1", 128'(core_ack), 128'(oh0));
      step;
      lsc_readData = rnd128();
      core_writeData[127:0] = rnd128();
      #1;
      chk("mid_ack2", 128'(core_ack), 128'(oh0));
      rst = 1'b1;
      #1;
      chk_zero("mid_rst");
      lsc_ready = 1'b0;
      lsc_ack = 1'b0;
      set_core(3, 1'b0, 1);
      step;
      #1;
      chk("rst_quiet", 128'({core_done, core_err}), 128'(0));
      step;
      rst = 1'b0;
      m_ptr = 0;
      do_txn(0, 2, lat);
      chk("post_rst_lat", 128'(lat), 128'(2));
      do_txn(3, 1, lat);

      // randomized traffic against the round-robin model
      for (int it = 0; it < 12; it++) begin
         for (int i = 0; i < N; i++) begin
            if (!m_req[i] && $urandom_range(1, 0) == 1) begin
               set_core(i, 1'($urandom_range(1, 0)), $urandom_range(5, 0));
            end
         end
         if (m_req == '0) set_core(it % N, 1'b0, 1);
         g = pick(m_req);
         do_txn(g, int'(m_len[g]), lat);
         chk("rnd_lat", 128'(lat), 128'(3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
